// File: rtl/serial_frame_checker.sv
// Serial frame receiver: recovers start/data/parity/stop words from one line,
// strobes good words out in parallel and counts parity/framing errors.
module serial_frame_checker #(
    parameter int N         = 8,
    parameter int TICKS     = 16,
    parameter int PARITY_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         busy,
    output logic [15:0]  frame_cnt,
    output logic [15:0]  err_cnt
);
    localparam int CW = $clog2(TICKS);
    localparam int BW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t         state, nxt;
    logic           s1, rx_s;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [BW-1:0]  bitn, bit_nxt;
    logic [N-1:0]   sh, sh_nxt, sh_shift;
    logic           perr, perr_nxt;
    logic           ok_p, pe_p, fe_p;
    logic           half, last;

    assign half = (cnt == CW'(TICKS / 2 - 1));
    assign last = (cnt == CW'(TICKS - 1));
    assign busy = (state != IDLE);

    // LSB-first shift: newest bit enters at the top.
    always_comb begin
        for (int i = 0; i < N - 1; i++) sh_shift[i] = sh[i+1];
        sh_shift[N-1] = rx_s;
    end

    always_comb begin
        nxt      = state;
        cnt_nxt  = CW'(cnt + 1'b1);
        bit_nxt  = bitn;
        sh_nxt   = sh;
        perr_nxt = perr;
        ok_p     = 1'b0;
        pe_p     = 1'b0;
        fe_p     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) nxt = START;
            end
            START: if (half) begin
                cnt_nxt  = '0;
                bit_nxt  = '0;
                perr_nxt = 1'b0;
                nxt      = rx_s ? IDLE : DATA;
            end
            DATA: if (last) begin
                cnt_nxt = '0;
                sh_nxt  = sh_shift;
                bit_nxt = BW'(bitn + 1'b1);
                if (bitn == BW'(N - 1)) nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (last) begin
                cnt_nxt  = '0;
                perr_nxt = (^sh) ^ rx_s;
                nxt      = STOP;
            end
            STOP: if (last) begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    fe_p = 1'b1;
                    nxt  = WAIT_HIGH;
                end else begin
                    pe_p = perr;
                    ok_p = !perr;
                    nxt  = IDLE;
                end
            end
            WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rx_s) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1         <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bitn       <= '0;
            sh         <= '0;
            perr       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            s1         <= data;
            rx_s       <= s1;
            state      <= nxt;
            cnt        <= cnt_nxt;
            bitn       <= bit_nxt;
            sh         <= sh_nxt;
            perr       <= perr_nxt;
            dout_valid <= ok_p;
            parity_err <= pe_p;
            frame_err  <= fe_p;
            if (ok_p) dout <= sh;
            if (ok_p && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            if ((pe_p || fe_p) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule
